// File: rtl/bus_dispatch_ctrl_pkg.sv
// Shared types and constants for the bus dispatch controller: FSM state encoding,
// slave-select decode values and the default word width.
package bus_dispatch_ctrl_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD1 = 3'd1,
    SEL1  = 3'd2,
    LOAD2 = 3'd3,
    SEL2  = 3'd4
  } state_t;

  localparam logic [2:0] DEC_HSEL0 = 3'b001;
  localparam logic [2:0] DEC_HSEL1 = 3'b010;
  localparam logic [2:0] DEC_HSEL2 = 3'b011;

endpackage

// File: rtl/bus_dispatch_fsm.sv
// Free-running load/select sequencer: IDLE -> LOAD1 -> SEL1 -> LOAD2 -> SEL2 -> LOAD1.
// The Moore outputs are registered alongside the state, so they change on the same edge.
module bus_dispatch_fsm
  import bus_dispatch_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  output state_t o_state,
  output logic   o_sel1,
  output logic   o_sel2,
  output logic   o_mux1
);

  state_t r_state;
  logic   r_sel1;
  logic   r_sel2;
  logic   r_mux1;

  // Each branch loads the next state and the outputs that belong to that next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sel1  <= 1'b0;
      r_sel2  <= 1'b0;
      r_mux1  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, SEL2: begin
          r_state <= LOAD1;
          r_sel1  <= 1'b1;
          r_sel2  <= 1'b0;
          r_mux1  <= 1'b0;
        end
        LOAD1: begin
          r_state <= SEL1;
          r_sel1  <= 1'b0;
          r_sel2  <= 1'b0;
          r_mux1  <= 1'b0;
        end
        SEL1: begin
          r_state <= LOAD2;
          r_sel1  <= 1'b0;
          r_sel2  <= 1'b1;
          r_mux1  <= 1'b0;
        end
        LOAD2: begin
          r_state <= SEL2;
          r_sel1  <= 1'b0;
          r_sel2  <= 1'b0;
          r_mux1  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_sel1  <= 1'b0;
          r_sel2  <= 1'b0;
          r_mux1  <= 1'b0;
        end
      endcase
    end
  end

  assign o_state = r_state;
  assign o_sel1  = r_sel1;
  assign o_sel2  = r_sel2;
  assign o_mux1  = r_mux1;

endmodule

// File: rtl/bus_dispatch_ctrl.sv
// Two-source bus dispatcher: alternately captures a word from each source and decodes
// its select field onto one of three slave selects during the following select cycle.
module bus_dispatch_ctrl
  import bus_dispatch_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEC_MSB = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  output logic              hsel_0,
  output logic              hsel_1,
  output logic              hsel_2,
  output logic              sel1,
  output logic              sel2,
  output logic              mux1,
  output state_t            o_state_dbg
);

  state_t            w_state;
  logic              w_sel1;
  logic              w_sel2;
  logic              w_mux1;
  logic [DATA_W-1:0] r_hold1;
  logic [DATA_W-1:0] r_hold2;
  logic [DATA_W-1:0] w_mux;
  logic [2:0]        w_field;
  logic              w_sel_phase;
  logic              w_unused;

  bus_dispatch_fsm u_fsm (
    .clk     (clk),
    .rst     (rst),
    .o_state (w_state),
    .o_sel1  (w_sel1),
    .o_sel2  (w_sel2),
    .o_mux1  (w_mux1)
  );

  // Inputs are only sampled on a load cycle, so X/Z elsewhere never reaches the decoder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold1 <= '0;
      r_hold2 <= '0;
    end else begin
      if (w_sel1) r_hold1 <= data_in1;
      if (w_sel2) r_hold2 <= data_in2;
    end
  end

  assign w_mux       = w_mux1 ? r_hold2 : r_hold1;
  assign w_field     = w_mux[DEC_MSB -: 3];
  assign w_sel_phase = (w_state == SEL1) || (w_state == SEL2);
  assign w_unused    = ^w_mux;

  assign hsel_0      = w_sel_phase && (w_field == DEC_HSEL0);
  assign hsel_1      = w_sel_phase && (w_field == DEC_HSEL1);
  assign hsel_2      = w_sel_phase && (w_field == DEC_HSEL2);
  assign sel1        = w_sel1;
  assign sel2        = w_sel2;
  assign mux1        = w_mux1;
  assign o_state_dbg = w_state;

endmodule

// File: tb/tb_bus_dispatch_ctrl.sv
// Bench for bus_dispatch_ctrl: a cycle model pushes the expected output vector
// {state, sel1, sel2, mux1, hsel_2, hsel_1, hsel_0} per clock; each test pops and compares.
module tb_bus_dispatch_ctrl;
  import bus_dispatch_ctrl_pkg::*;

  localparam int W  = 16;
  localparam int VW = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in1;
  logic [W-1:0] data_in2;
  logic         hsel_0, hsel_1, hsel_2;
  logic         sel1, sel2, mux1;
  state_t       o_state_dbg;

  logic [VW-1:0] exp_q[$];
  int            vectors     = 0;
  int            miscompares = 0;

  state_t        m_state;
  logic [W-1:0]  m_h1;
  logic [W-1:0]  m_h2;
  logic [W-1:0]  words [4];

  bus_dispatch_ctrl #(.DATA_W(W), .DEC_MSB(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in1    (data_in1),
    .data_in2    (data_in2),
    .hsel_0      (hsel_0),
    .hsel_1      (hsel_1),
    .hsel_2      (hsel_2),
    .sel1        (sel1),
    .sel2        (sel2),
    .mux1        (mux1),
    .o_state_dbg (o_state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] obs();
    return {o_state_dbg, sel1, sel2, mux1, hsel_2, hsel_1, hsel_0};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic       s1, s2, mx;
    logic [2:0] f;
    logic [2:0] h;
    s1 = (m_state == LOAD1);
    s2 = (m_state == LOAD2);
    mx = (m_state == SEL2);
    f  = (m_state == SEL1) ? m_h1[15:13] : m_h2[15:13];
    h  = 3'b000;
    if (m_state == SEL1 || m_state == SEL2) begin
      case (f)
        3'b001:  h = 3'b001;
        3'b010:  h = 3'b010;
        3'b011:  h = 3'b100;
        default: h = 3'b000;
      endcase
    end
    return {m_state, s1, s2, mx, h};
  endfunction

  task automatic model_reset();
    m_state = IDLE;
    m_h1    = '0;
    m_h2    = '0;
  endtask

  // Drives one cycle of data (called at a negedge), advances the model and queues the
  // expectation, then returns at the next negedge ready for sampling.
  task automatic drive_cycle(input logic [W-1:0] d1, input logic [W-1:0] d2);
    data_in1 = d1;
    data_in2 = d2;
    if (m_state == LOAD1) m_h1 = d1;
    if (m_state == LOAD2) m_h2 = d2;
    case (m_state)
      IDLE, SEL2: m_state = LOAD1;
      LOAD1:      m_state = SEL1;
      SEL1:       m_state = LOAD2;
      LOAD2:      m_state = SEL2;
      default:    m_state = IDLE;
    endcase
    exp_q.push_back(model_vec());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [VW-1:0] got;
    rst      = 1'b0;
    data_in1 = 16'h2008;
    data_in2 = 16'h0000;
    model_reset();
    repeat (20) begin
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== {IDLE, 6'b000000}) begin
        miscompares++;
        $display("FAIL reset_hold: got %b, need %b", got, {IDLE, 6'b000000});
      end
    end
  endtask

  task automatic test_basic();
    logic [VW-1:0] got, exp;
    logic [4:0]    want;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(16'h2008, 16'h4008);
      got = obs();
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL basic cyc %0d: got %b, need %b", i + 1, got, exp);
      end
      // {sel1, sel2, mux1, hsel_0, hsel_1} for cycles 1..4 of the repeating pattern
      case (i % 4)
        0:       want = 5'b10000;
        1:       want = 5'b00010;
        2:       want = 5'b01000;
        default: want = 5'b00101;
      endcase
      vectors++;
      if ({sel1, sel2, mux1, hsel_0, hsel_1} !== want) begin
        miscompares++;
        $display("FAIL latency cyc %0d: got %b, need %b", i + 1,
                 {sel1, sel2, mux1, hsel_0, hsel_1}, want);
      end
    end
  endtask

  task automatic test_decode();
    logic [VW-1:0] got, exp;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(16'h6008, 16'h8008);
      got = obs();
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL decode cyc %0d: got %b, need %b", i, got, exp);
      end
    end
  endtask

  task automatic test_hold();
    logic [VW-1:0] got, exp;
    logic [W-1:0]  d1, d2;
    for (int i = 0; i < 20; i++) begin
      d1 = ($urandom_range(0, 1) == 1) ? 'x : W'($urandom());
      d2 = ($urandom_range(0, 1) == 1) ? 'x : W'($urandom());
      if (m_state == LOAD1) d1 = words[$urandom_range(0, 3)];
      if (m_state == LOAD2) d2 = words[$urandom_range(0, 3)];
      drive_cycle(d1, d2);
      got = obs();
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL hold cyc %0d: got %b, need %b", i, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] got, exp;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(W'($urandom()), W'($urandom()));
      got = obs();
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %b, need %b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] got, exp;
    bit            reached;
    reached = 1'b0;
    for (int i = 0; i < 8 && !reached; i++) begin
      drive_cycle(16'h2008, 16'h4008);
      got = obs();
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL mid_pre cyc %0d: got %b, need %b", i, got, exp);
      end
      if (m_state == SEL2) reached = 1'b1;
    end
    vectors++;
    if (!reached || hsel_1 !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_sel2: got hsel_1=%b state=%0d, need hsel_1=1 in SEL2", hsel_1, o_state_dbg);
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    got = obs();
    vectors++;
    if (got !== {IDLE, 6'b000000}) begin
      miscompares++;
      $display("FAIL async_reset: got %b, need %b", got, {IDLE, 6'b000000});
    end
    @(negedge clk);
    got = obs();
    vectors++;
    if (got !== {IDLE, 6'b000000}) begin
      miscompares++;
      $display("FAIL reset_held: got %b, need %b", got, {IDLE, 6'b000000});
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(16'h6008, 16'h2008);
      got = obs();
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL restart cyc %0d: got %b, need %b", i + 1, got, exp);
      end
    end
  endtask

  initial begin
    words[0] = 16'h2008;
    words[1] = 16'h4008;
    words[2] = 16'h6008;
    words[3] = 16'h8008;
    test_reset();
    test_basic();
    test_decode();
    test_hold();
    test_random();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d left, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_dispatch_ctrl.md
BUS_DISPATCH_CTRL -- requirements
Module: bus_dispatch_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, width of both input words and the holding registers.
REQ-002 Parameter DEC_MSB, default 15, MSB of the 3-bit select field decoded to hsel.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 data_in1  input  DATA_W  word from source 1.
REQ-006 data_in2  input  DATA_W  word from source 2.
REQ-007 hsel_0  output  1  slave-0 select.
REQ-008 hsel_1  output  1  slave-1 select.
REQ-009 hsel_2  output  1  slave-2 select.
REQ-010 sel1  output  1  load enable of holding register 1 (FSM output, observable).
REQ-011 sel2  output  1  load enable of holding register 2 (FSM output, observable).
REQ-012 mux1  output  1  output-mux select: 0 = register 1, 1 = register 2 (FSM output, observable).

Function
REQ-013 FSM states: IDLE, LOAD1, SEL1, LOAD2, SEL2.
- Transitions are unconditional, one per rising clk: IDLE->LOAD1->SEL1->LOAD2->SEL2->LOAD1, repeating.
REQ-014 FSM outputs are Moore, decoded from state only:
- sel1 = 1 in LOAD1 only.
- sel2 = 1 in LOAD2 only.
- mux1 = 1 in SEL2 only; 0 in every other state.
REQ-015 Holding register 1 (DATA_W bits) captures data_in1 on the rising edge that ends a cycle with sel1=1; otherwise it holds its value.
REQ-016 Holding register 2 captures data_in2 on the same rule, using sel2.
REQ-017 The mux output is register 1 when mux1=0 and register 2 when mux1=1.
REQ-018 Decode field = mux output [DEC_MSB:DEC_MSB-2].
- 3'b001 -> hsel_0.
- 3'b010 -> hsel_1.
- 3'b011 -> hsel_2.
- Any other value -> no hsel asserted.
REQ-019 The hsel outputs are combinational from state and the holding registers.
- The decoded hsel is asserted only while the FSM is in SEL1 or SEL2.
- All hsel outputs are 0 in IDLE, LOAD1 and LOAD2.
- At most one hsel output is high at any time.
REQ-020 Latency: a word present on data_in1 during LOAD1 appears on hsel in the immediately following cycle (SEL1). The same holds for data_in2, LOAD2 and SEL2.
REQ-021 Input changes outside LOAD1/LOAD2 have no effect on the outputs until the next load of that register.
REQ-022 X/Z on data inputs while not loading shall not propagate to hsel.

Reset
REQ-023 While rst=0, asynchronously:
- FSM = IDLE.
- Both holding registers = 0.
- sel1 = sel2 = mux1 = 0.
- hsel_0..2 = 0.
REQ-024 Reset asserted mid-sequence aborts immediately, with no partial load.
REQ-025 After rst rises, the first rising clk moves the FSM IDLE->LOAD1.

Structure
REQ-026 A shared package holds:
- the state enumeration (3-bit encoding);
- decode constants 3'b001, 3'b010, 3'b011;
- the DATA_W default.
REQ-027 One sub-module, bus_dispatch_fsm, holds the state register and the sel1/sel2/mux1 decode.
REQ-028 The datapath (registers, mux, decoder) is written inline in bus_dispatch_ctrl.

Verification
REQ-029 Reset held at 0 for 200 ns with data_in1=16'h2008 -> hsel_0..2, sel1, sel2 and mux1 stay 0 and the FSM stays IDLE.
REQ-030 Release reset with data_in1=16'h2008 and data_in2=16'h4008:
- sel1 high in cycle 1; hsel_0 high in cycle 2.
- sel2 high in cycle 3; hsel_1 high and mux1=1 in cycle 4.
- The pattern repeats every 4 cycles.
REQ-031 data_in1=16'h6008 loaded in LOAD1 -> hsel_2 high in the following SEL1 cycle; hsel_0 and hsel_1 stay low.
REQ-032 data_in2=16'h8008 (field 3'b100) -> no hsel asserted during SEL2.
REQ-033 Change data_in1 during SEL1 -> hsel is unchanged until the next SEL1.
REQ-034 Assert rst during SEL2 -> all outputs go to 0 within the same cycle, without waiting for clk; on release the sequence restarts at LOAD1.
